// File: rtl/be_arbiter.sv
// be_arbiter: two-requester (load/store) command arbiter that feeds a
// byte-enable generator and routes its beats back to the granted requester.
// Requests are accepted only in IDLE, with round-robin priority on ties.
// A command with zero elements skips the generator. A command whose first
// beat never arrives ends with an error pulse after TIMEOUT cycles.
module be_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  // requester 0 (load unit)
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_addr_i,
  input  logic [31:0] req0_stride_i,
  input  logic [4:0]  req0_vl_i,
  output logic        req0_be_valid_o,
  output logic        req0_done_o,
  output logic        req0_err_o,
  // requester 1 (store unit)
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_addr_i,
  input  logic [31:0] req1_stride_i,
  input  logic [4:0]  req1_vl_i,
  output logic        req1_be_valid_o,
  output logic        req1_done_o,
  output logic        req1_err_o,
  // shared beat outputs
  output logic [3:0]  be_o,
  output logic [5:0]  done_beats_o,
  // generator side
  output logic        gen_load_first_o,
  output logic [31:0] gen_base_addr_o,
  output logic [31:0] gen_stride_o,
  output logic [4:0]  gen_vl_o,
  input  logic [3:0]  gen_cycle_be_i,
  input  logic        gen_out_valid_i
);

  localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  state_t          state_q;
  logic            last_grant_q;  // index granted on the most recent accept
  logic            gnt_q;         // index owning the current transaction
  logic [31:0]     cmd_addr_q;
  logic [31:0]     cmd_stride_q;
  logic [4:0]      cmd_vl_q;
  logic [5:0]      beat_cnt_q;
  logic [WCW-1:0]  wait_cnt_q;
  logic            load_first_q;
  logic            done_q;
  logic            err_q;
  logic [5:0]      done_beats_q;

  logic            any_valid;
  logic            grant_idx;
  logic            accept;
  logic            fwd_beat;
  logic [5:0]      beat_inc;
  logic [31:0]     sel_addr;
  logic [31:0]     sel_stride;
  logic [4:0]      sel_vl;

  // Round-robin grant selection and the command fields of the chosen requester.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_idx  = 1'b0;
    any_valid  = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      grant_idx = ~last_grant_q;
    end else if (req1_valid_i) begin
      grant_idx = 1'b1;
    end
    sel_addr   = grant_idx ? req1_addr_i   : req0_addr_i;
    sel_stride = grant_idx ? req1_stride_i : req0_stride_i;
    sel_vl     = grant_idx ? req1_vl_i     : req0_vl_i;
    // Ready is also gated by reset so that every output reads 0 while reset is held.
    accept     = n_rst_i && (state_q == S_IDLE) && any_valid;
    fwd_beat   = ((state_q == S_WAIT) || (state_q == S_STREAM)) && gen_out_valid_i;
    beat_inc   = (beat_cnt_q == 6'd63) ? beat_cnt_q : beat_cnt_q + 6'd1;
  end

  // Control FSM together with the command latch, the counters and the registered pulses.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      // NOTE: every state element, including the command latch, has a reset value so no
      // stale command or pulse survives an abort.
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;  // requester 0 wins the first tie
      gnt_q        <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_stride_q <= '0;
      cmd_vl_q     <= '0;
      beat_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      load_first_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      done_beats_q <= '0;
    end else begin
      // NOTE: non-blocking assignments only, so every branch sees the pre-edge values.
      load_first_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      done_beats_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            last_grant_q <= grant_idx;
            gnt_q        <= grant_idx;
            cmd_addr_q   <= sel_addr;
            cmd_stride_q <= sel_stride;
            cmd_vl_q     <= sel_vl;
            beat_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            if (sel_vl == 5'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_LAUNCH;
              load_first_q <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          state_q    <= S_WAIT;
          wait_cnt_q <= '0;
        end
        S_WAIT: begin
          if (gen_out_valid_i) begin
            beat_cnt_q <= beat_inc;
            state_q    <= S_STREAM;
          end else if (wait_cnt_q == WCW'(TIMEOUT - 1)) begin
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            err_q        <= 1'b1;
            done_beats_q <= beat_cnt_q;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_STREAM: begin
          if (gen_out_valid_i) begin
            beat_cnt_q <= beat_inc;
          end else begin
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            done_beats_q <= beat_cnt_q;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output steering: ready and beats are zero-latency and go only to the owning requester.
  always_comb begin
    req0_ready_o     = accept & ~grant_idx;
    req1_ready_o     = accept &  grant_idx;
    req0_be_valid_o  = fwd_beat & ~gnt_q;
    req1_be_valid_o  = fwd_beat &  gnt_q;
    be_o             = fwd_beat ? gen_cycle_be_i : 4'd0;
    req0_done_o      = done_q & ~gnt_q;
    req1_done_o      = done_q &  gnt_q;
    req0_err_o       = err_q  & ~gnt_q;
    req1_err_o       = err_q  &  gnt_q;
    done_beats_o     = done_beats_q;
    gen_load_first_o = load_first_q;
    if (state_q != S_IDLE) begin
      gen_base_addr_o = cmd_addr_q;
      gen_stride_o    = cmd_stride_q;
      gen_vl_o        = cmd_vl_q;
    end else begin
      gen_base_addr_o = '0;
      gen_stride_o    = '0;
      gen_vl_o        = '0;
    end
  end

endmodule

// File: tb/tb_be_arbiter.sv
// Testbench for be_arbiter: a table of hand-computed transactions, each run
// cycle by cycle against the expected timing. Hand-written sequences cover
// reset and an abort in the middle of a stream.
module tb_be_arbiter;

  localparam int TIMEOUT = 8;

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_addr_i, req0_stride_i, req1_addr_i, req1_stride_i;
  logic [4:0]  req0_vl_i, req1_vl_i;
  logic        req0_be_valid_o, req0_done_o, req0_err_o;
  logic        req1_be_valid_o, req1_done_o, req1_err_o;
  logic [3:0]  be_o;
  logic [5:0]  done_beats_o;
  logic        gen_load_first_o;
  logic [31:0] gen_base_addr_o, gen_stride_o;
  logic [4:0]  gen_vl_o;
  logic [3:0]  gen_cycle_be_i;
  logic        gen_out_valid_i;

  always #5 clk_i = ~clk_i;

  be_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i           (clk_i),
    .n_rst_i         (n_rst_i),
    .req0_valid_i    (req0_valid_i),
    .req0_ready_o    (req0_ready_o),
    .req0_addr_i     (req0_addr_i),
    .req0_stride_i   (req0_stride_i),
    .req0_vl_i       (req0_vl_i),
    .req0_be_valid_o (req0_be_valid_o),
    .req0_done_o     (req0_done_o),
    .req0_err_o      (req0_err_o),
    .req1_valid_i    (req1_valid_i),
    .req1_ready_o    (req1_ready_o),
    .req1_addr_i     (req1_addr_i),
    .req1_stride_i   (req1_stride_i),
    .req1_vl_i       (req1_vl_i),
    .req1_be_valid_o (req1_be_valid_o),
    .req1_done_o     (req1_done_o),
    .req1_err_o      (req1_err_o),
    .be_o            (be_o),
    .done_beats_o    (done_beats_o),
    .gen_load_first_o(gen_load_first_o),
    .gen_base_addr_o (gen_base_addr_o),
    .gen_stride_o    (gen_stride_o),
    .gen_vl_o        (gen_vl_o),
    .gen_cycle_be_i  (gen_cycle_be_i),
    .gen_out_valid_i (gen_out_valid_i)
  );

  typedef struct {
    logic        v0;
    logic        v1;
    logic [31:0] addr;
    logic [31:0] stride;
    logic [4:0]  vl;
    int          beats;      // beats the generator stub delivers (0 = never)
    logic [3:0]  be;
    logic        exp_gnt;
    logic [5:0]  exp_beats;
    logic        exp_err;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // The requester that does not own the transaction must stay silent.
  task automatic chk_other(input string tag, input logic g);
    if (g) begin
      check({tag, " ready0"},    32'(req0_ready_o),    32'd0);
      check({tag, " be_valid0"}, 32'(req0_be_valid_o), 32'd0);
      check({tag, " done0"},     32'(req0_done_o),     32'd0);
      check({tag, " err0"},      32'(req0_err_o),      32'd0);
    end else begin
      check({tag, " ready1"},    32'(req1_ready_o),    32'd0);
      check({tag, " be_valid1"}, 32'(req1_be_valid_o), 32'd0);
      check({tag, " done1"},     32'(req1_done_o),     32'd0);
      check({tag, " err1"},      32'(req1_err_o),      32'd0);
    end
  endtask

  // The non-granted requester gets a different command so that a wrong mux select is visible.
  task automatic drive_req(input vec_t v);
    req0_valid_i = v.v0;
    req1_valid_i = v.v1;
    if (!v.exp_gnt) begin
      req0_addr_i = v.addr; req0_stride_i = v.stride; req0_vl_i = v.vl;
      req1_addr_i = v.addr ^ 32'hFFFF_0000; req1_stride_i = v.stride + 32'd3; req1_vl_i = 5'd9;
    end else begin
      req1_addr_i = v.addr; req1_stride_i = v.stride; req1_vl_i = v.vl;
      req0_addr_i = v.addr ^ 32'hFFFF_0000; req0_stride_i = v.stride + 32'd3; req0_vl_i = 5'd9;
    end
  endtask

  // Runs one transaction starting in an IDLE cycle (T) and returns in the IDLE cycle after DONE.
  task automatic run_txn(input int idx, input vec_t v);
    string t;
    logic  g;
    g = v.exp_gnt;
    t = $sformatf("v%0d", idx);
    drive_req(v);
    gen_out_valid_i = 1'b1;  // must be ignored while IDLE
    gen_cycle_be_i  = 4'hF;
    #3;
    check({t, " ready_gnt"},      32'(g ? req1_ready_o : req0_ready_o), 32'd1);
    check({t, " idle be_valid"},  32'(g ? req1_be_valid_o : req0_be_valid_o), 32'd0);
    check({t, " idle done"},      32'(g ? req1_done_o : req0_done_o), 32'd0);
    check({t, " idle load_first"}, 32'(gen_load_first_o), 32'd0);
    chk_other({t, " idle"}, g);
    step();  // T+1
    if (g) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
    if (v.vl == 5'd0) begin
      #3;
      check({t, " vl0 done"},       32'(g ? req1_done_o : req0_done_o), 32'd1);
      check({t, " vl0 err"},        32'(g ? req1_err_o : req0_err_o), 32'd0);
      check({t, " vl0 done_beats"}, 32'(done_beats_o), 32'd0);
      check({t, " vl0 load_first"}, 32'(gen_load_first_o), 32'd0);
      check({t, " vl0 be_valid"},   32'(g ? req1_be_valid_o : req0_be_valid_o), 32'd0);
      chk_other({t, " vl0"}, g);
      gen_out_valid_i = 1'b0;
      step();
      return;
    end
    #3;  // LAUNCH, generator valid still high and ignored
    check({t, " load_first"}, 32'(gen_load_first_o), 32'd1);
    check({t, " gen_addr"},   gen_base_addr_o, v.addr);
    check({t, " gen_stride"}, gen_stride_o, v.stride);
    check({t, " gen_vl"},     32'(gen_vl_o), 32'(v.vl));
    check({t, " launch be_valid"}, 32'(g ? req1_be_valid_o : req0_be_valid_o), 32'd0);
    chk_other({t, " launch"}, g);
    step();  // T+2: first WAIT cycle
    if (v.beats == 0) begin
      gen_out_valid_i = 1'b0;
      for (int i = 0; i < TIMEOUT; i++) begin
        #3;
        check({t, " wait be_valid"},   32'(g ? req1_be_valid_o : req0_be_valid_o), 32'd0);
        check({t, " wait done"},       32'(g ? req1_done_o : req0_done_o), 32'd0);
        check({t, " wait load_first"}, 32'(gen_load_first_o), 32'd0);
        check({t, " wait gen_vl"},     32'(gen_vl_o), 32'(v.vl));
        chk_other({t, " wait"}, g);
        step();
      end
    end else begin
      for (int i = 0; i < v.beats; i++) begin
        gen_out_valid_i = 1'b1;
        gen_cycle_be_i  = v.be;
        #3;
        check({t, " beat be_valid"}, 32'(g ? req1_be_valid_o : req0_be_valid_o), 32'd1);
        check({t, " beat be"},       32'(be_o), 32'(v.be));
        check({t, " beat stride"},   gen_stride_o, v.stride);
        check({t, " beat done"},     32'(g ? req1_done_o : req0_done_o), 32'd0);
        chk_other({t, " beat"}, g);
        step();
      end
      gen_out_valid_i = 1'b0;  // end of contiguous run
      #3;
      check({t, " end be_valid"}, 32'(g ? req1_be_valid_o : req0_be_valid_o), 32'd0);
      check({t, " end be"},       32'(be_o), 32'd0);
      check({t, " end done"},     32'(g ? req1_done_o : req0_done_o), 32'd0);
      chk_other({t, " end"}, g);
      step();
    end
    gen_out_valid_i = 1'b1;  // must be ignored while DONE
    #3;
    check({t, " done"},          32'(g ? req1_done_o : req0_done_o), 32'd1);
    check({t, " err"},           32'(g ? req1_err_o : req0_err_o), 32'(v.exp_err));
    check({t, " done_beats"},    32'(done_beats_o), 32'(v.exp_beats));
    check({t, " done be_valid"}, 32'(g ? req1_be_valid_o : req0_be_valid_o), 32'd0);
    chk_other({t, " done"}, g);
    gen_out_valid_i = 1'b0;
    step();  // back in IDLE
  endtask

  vec_t vecs[8];
  vec_t v_post;

  initial begin
    // v0, v1, addr, stride, vl, beats, be, exp_gnt, exp_beats, exp_err
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'd1, 5'd4,  1,  4'hF, 1'b0, 6'd1,  1'b0}; // tie after reset -> req0
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'd4, 5'd3,  3,  4'h1, 1'b1, 6'd3,  1'b0}; // pending req1 wins tie
    vecs[2] = '{1'b1, 1'b1, 32'h0000_3000, 32'd2, 5'd0,  0,  4'h0, 1'b0, 6'd0,  1'b0}; // third tie -> req0, vl 0
    vecs[3] = '{1'b0, 1'b1, 32'h0000_4000, 32'd8, 5'd5,  0,  4'h0, 1'b1, 6'd0,  1'b1}; // timeout on req1
    vecs[4] = '{1'b0, 1'b1, 32'h0000_5000, 32'd2, 5'd2,  2,  4'hA, 1'b1, 6'd2,  1'b0}; // lone req1 despite priority
    vecs[5] = '{1'b1, 1'b0, 32'h0000_6000, 32'd1, 5'd7,  4,  4'h5, 1'b0, 6'd4,  1'b0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_7000, 32'd1, 5'd31, 65, 4'hC, 1'b0, 6'd63, 1'b0}; // counter saturation
    vecs[7] = '{1'b1, 1'b1, 32'h0000_8000, 32'd3, 5'd6,  2,  4'h9, 1'b1, 6'd2,  1'b0}; // tie after req0 -> req1

    // Reset state: valids high while held in reset, every output must read 0.
    n_rst_i = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    req0_addr_i = 32'h1; req0_stride_i = 32'h1; req0_vl_i = 5'd1;
    req1_addr_i = 32'h2; req1_stride_i = 32'h2; req1_vl_i = 5'd2;
    gen_out_valid_i = 1'b1; gen_cycle_be_i = 4'hF;
    #3;
    check("rst ready0",      32'(req0_ready_o), 32'd0);
    check("rst ready1",      32'(req1_ready_o), 32'd0);
    check("rst be",          32'(be_o), 32'd0);
    check("rst load_first",  32'(gen_load_first_o), 32'd0);
    check("rst gen_addr",    gen_base_addr_o, 32'd0);
    check("rst done_beats",  32'(done_beats_o), 32'd0);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; gen_out_valid_i = 1'b0;
    step();
    step();
    n_rst_i = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(i, vecs[i]);
    end
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b0;
    step();

    // Abort during STREAM: outputs drop at once, no completion pulse follows.
    req0_valid_i = 1'b1; req0_addr_i = 32'h0000_9000; req0_stride_i = 32'd1; req0_vl_i = 5'd4;
    #3;
    check("abort ready0", 32'(req0_ready_o), 32'd1);
    step();  // LAUNCH
    req0_valid_i = 1'b0;
    step();  // WAIT
    gen_out_valid_i = 1'b1; gen_cycle_be_i = 4'h6;
    step();  // STREAM
    #1;
    check("abort pre be_valid0", 32'(req0_be_valid_o), 32'd1);
    req0_valid_i = 1'b1;
    n_rst_i = 1'b0;
    #1;
    check("abort be_valid0",   32'(req0_be_valid_o), 32'd0);
    check("abort be",          32'(be_o), 32'd0);
    check("abort ready0",      32'(req0_ready_o), 32'd0);
    check("abort gen_addr",    gen_base_addr_o, 32'd0);
    check("abort gen_vl",      32'(gen_vl_o), 32'd0);
    check("abort done0",       32'(req0_done_o), 32'd0);
    check("abort err0",        32'(req0_err_o), 32'd0);
    check("abort done_beats",  32'(done_beats_o), 32'd0);
    step();
    n_rst_i = 1'b1;
    req0_valid_i = 1'b0;
    gen_out_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("post abort done0", 32'(req0_done_o), 32'd0);
      check("post abort err0",  32'(req0_err_o), 32'd0);
      check("post abort be0",   32'(req0_be_valid_o), 32'd0);
      step();
    end

    // After reset the tie goes to req0 again even though req0 was granted last.
    v_post = '{1'b1, 1'b1, 32'h0000_A000, 32'd2, 5'd2, 2, 4'h3, 1'b0, 6'd2, 1'b0};
    run_txn(100, v_post);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
